// File: rtl/ce_pkg.sv
// Shared types and width helpers for the CE frame scheduler.
package ce_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int x_width(input int out_w);
        return clog2_min1(out_w);
    endfunction

    function automatic int y_width(input int out_h);
        return clog2_min1(out_h);
    endfunction

    function automatic int addr_width(input int out_w, input int out_h);
        return clog2_min1(out_w * out_h);
    endfunction

    function automatic int cred_width(input int cred);
        return clog2_min1(cred + 1);
    endfunction

endpackage

// File: rtl/ce_credit_cnt.sv
// Saturating up/down counter with a zero flag; used for both the credit
// pool and the count of results still in flight inside the CE.
module ce_credit_cnt
    import ce_pkg::*;
#(
    parameter int W       = 3,
    parameter int MAX     = 4,
    parameter int RST_VAL = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic zero
);

    logic [W-1:0] count;

    // Simultaneous inc and dec cancel; each direction holds at its limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= W'(RST_VAL);
        end else if (clr) begin
            count <= W'(RST_VAL);
        end else if (inc && !dec) begin
            if (count != W'(MAX))
                count <= count + W'(1);
        end else if (dec && !inc) begin
            if (count != '0)
                count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ce_sched.sv
// Frame scheduler: walks output positions in raster order, issues one window
// per position to the CE under credit control and tags CE results with addresses.
module ce_sched
    import ce_pkg::*;
#(
    parameter  int OUT_W = 28,
    parameter  int OUT_H = 28,
    parameter  int CRED  = 4,
    localparam int XW    = x_width(OUT_W),
    localparam int YW    = y_width(OUT_H),
    localparam int AW    = addr_width(OUT_W, OUT_H),
    localparam int CW    = cred_width(CRED)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    input  logic          win_vld,
    output logic          win_pop,
    output logic [XW-1:0] win_x,
    output logic [YW-1:0] win_y,
    output logic          ce_en_in,
    input  logic          ce_en_out,
    output logic          res_we,
    output logic [AW-1:0] res_addr,
    input  logic          cred_ret,
    output logic          err
);

    localparam logic [XW-1:0] X_LAST    = XW'(OUT_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(OUT_H - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(OUT_W * OUT_H - 1);

    state_t state, next_state;
    logic   issue;
    logic   frame_clr;
    logic   cred_zero;
    logic   outs_zero;
    logic   last_pos;

    assign last_pos = (win_x == X_LAST) && (win_y == Y_LAST);
    assign res_we   = ce_en_out && (state == RUN || state == DRAIN) && !outs_zero;
    assign win_pop  = issue;
    assign ce_en_in = issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        issue      = 1'b0;
        frame_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                    frame_clr  = 1'b1;
                end
            end
            RUN: begin
                busy  = 1'b1;
                issue = win_vld && !cred_zero;
                if (abort) begin
                    next_state = IDLE;
                    frame_clr  = 1'b1;
                end else if (issue && last_pos) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    next_state = IDLE;
                    frame_clr  = 1'b1;
                end else if (res_we && res_addr == ADDR_LAST) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Raster walk; the final issue wraps both coordinates back to the origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_x <= '0;
            win_y <= '0;
        end else if (frame_clr) begin
            win_x <= '0;
            win_y <= '0;
        end else if (issue) begin
            if (win_x == X_LAST) begin
                win_x <= '0;
                win_y <= (win_y == Y_LAST) ? '0 : win_y + YW'(1);
            end else begin
                win_x <= win_x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            res_addr <= '0;
        else if (frame_clr)
            res_addr <= '0;
        else if (res_we)
            res_addr <= res_addr + AW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (ce_en_out && !res_we)
            err <= 1'b1;
    end

    // Credits belong to the result buffer, so a new frame never refills them.
    ce_credit_cnt #(
        .W       (CW),
        .MAX     (CRED),
        .RST_VAL (CRED)
    ) u_credit (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .inc  (cred_ret),
        .dec  (issue),
        .zero (cred_zero)
    );

    ce_credit_cnt #(
        .W       (CW),
        .MAX     ((1 << CW) - 1),
        .RST_VAL (0)
    ) u_outstanding (
        .clk  (clk),
        .rst  (rst),
        .clr  (frame_clr),
        .inc  (issue),
        .dec  (ce_en_out),
        .zero (outs_zero)
    );

endmodule

// File: tb/tb_ce_sched.sv
// Directed bench for ce_sched: cycle tables for full frames plus hand-written
// sequences for reset, abort and credit corner cases (3x2 map, CRED 4 and 2).
module tb_ce_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, win_vld, ce_en_out, cred_ret;
    logic       busy, done, win_pop, ce_en_in, res_we, err;
    logic [1:0] win_x;
    logic [0:0] win_y;
    logic [2:0] res_addr;

    logic       start2, abort2, win_vld2, ce_en_out2, cred_ret2;
    logic       busy2, done2, win_pop2, ce_en_in2, res_we2, err2;
    logic [1:0] win_x2;
    logic [0:0] win_y2;
    logic [2:0] res_addr2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ce_sched #(.OUT_W(3), .OUT_H(2), .CRED(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .win_vld(win_vld), .win_pop(win_pop), .win_x(win_x), .win_y(win_y),
        .ce_en_in(ce_en_in), .ce_en_out(ce_en_out), .res_we(res_we),
        .res_addr(res_addr), .cred_ret(cred_ret), .err(err)
    );

    ce_sched #(.OUT_W(3), .OUT_H(2), .CRED(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .busy(busy2), .done(done2),
        .win_vld(win_vld2), .win_pop(win_pop2), .win_x(win_x2), .win_y(win_y2),
        .ce_en_in(ce_en_in2), .ce_en_out(ce_en_out2), .res_we(res_we2),
        .res_addr(res_addr2), .cred_ret(cred_ret2), .err(err2)
    );

    typedef struct {
        logic       start, abort, vld, ceo, cret;
        logic       busy, done, pop, chk_xy;
        logic [1:0] x;
        logic       y;
        logic       we;
        logic [2:0] addr;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int s, a, v, c, r, b, d, p, cxy, x, y, w, ad, e);
        vec_t t;
        t.start = s[0]; t.abort = a[0]; t.vld = v[0]; t.ceo = c[0]; t.cret = r[0];
        t.busy = b[0]; t.done = d[0]; t.pop = p[0]; t.chk_xy = cxy[0];
        t.x = x[1:0]; t.y = y[0]; t.we = w[0]; t.addr = ad[2:0]; t.err = e[0];
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s[%0d]: got %0d, want %0d", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        start     = v.start;
        abort     = v.abort;
        win_vld   = v.vld;
        ce_en_out = v.ceo;
        cred_ret  = v.cret;
    endtask

    task automatic checkOutput(input vec_t v, input string tag, input int idx);
        chk({tag, ".busy"}, idx, 32'(busy), 32'(v.busy));
        chk({tag, ".done"}, idx, 32'(done), 32'(v.done));
        chk({tag, ".win_pop"}, idx, 32'(win_pop), 32'(v.pop));
        chk({tag, ".ce_en_in"}, idx, 32'(ce_en_in), 32'(v.pop));
        if (v.chk_xy) begin
            chk({tag, ".win_x"}, idx, 32'(win_x), 32'(v.x));
            chk({tag, ".win_y"}, idx, 32'(win_y), 32'(v.y));
        end
        chk({tag, ".res_we"}, idx, 32'(res_we), 32'(v.we));
        chk({tag, ".res_addr"}, idx, 32'(res_addr), 32'(v.addr));
        chk({tag, ".err"}, idx, 32'(err), 32'(v.err));
    endtask

    task automatic runTable(input string tag);
        foreach (tbl[i]) begin
            @(negedge clk);
            applyStimulus(tbl[i]);
            #1;
            checkOutput(tbl[i], tag, i);
        end
        tbl.delete();
    endtask

    task automatic idleInputs();
        start = 0; abort = 0; win_vld = 0; ce_en_out = 0; cred_ret = 0;
        start2 = 0; abort2 = 0; win_vld2 = 0; ce_en_out2 = 0; cred_ret2 = 0;
    endtask

    task automatic checkResetValues(input string tag);
        chk({tag, ".busy"}, 0, 32'(busy), 0);
        chk({tag, ".done"}, 0, 32'(done), 0);
        chk({tag, ".win_pop"}, 0, 32'(win_pop), 0);
        chk({tag, ".ce_en_in"}, 0, 32'(ce_en_in), 0);
        chk({tag, ".win_x"}, 0, 32'(win_x), 0);
        chk({tag, ".win_y"}, 0, 32'(win_y), 0);
        chk({tag, ".res_we"}, 0, 32'(res_we), 0);
        chk({tag, ".res_addr"}, 0, 32'(res_addr), 0);
        chk({tag, ".err"}, 0, 32'(err), 0);
    endtask

    initial begin
        int pops;
        idleInputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Frame A: CE latency 5, cred_ret echoes res_we 3 cycles later.
        //                s a v c r  b d p xy x y  w a e
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,1, 0,0, 0,0,0));
        tbl.push_back(mk(1,0,1,0,0, 0,0,0,1, 0,0, 0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 1,0,1,1, 0,0, 0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 1,0,1,1, 1,0, 0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 1,0,1,1, 2,0, 0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 1,0,1,1, 0,1, 0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 1,0,0,1, 1,1, 0,0,0));
        tbl.push_back(mk(0,0,1,1,0, 1,0,0,1, 1,1, 1,0,0));
        tbl.push_back(mk(0,0,1,1,0, 1,0,0,1, 1,1, 1,1,0));
        tbl.push_back(mk(0,0,1,1,0, 1,0,0,1, 1,1, 1,2,0));
        tbl.push_back(mk(0,0,1,1,1, 1,0,0,1, 1,1, 1,3,0));
        tbl.push_back(mk(0,0,1,0,1, 1,0,1,1, 1,1, 0,4,0));
        tbl.push_back(mk(0,0,1,0,1, 1,0,1,1, 2,1, 0,4,0));
        tbl.push_back(mk(0,0,1,0,1, 1,0,0,0, 0,0, 0,4,0));
        tbl.push_back(mk(0,0,1,0,0, 1,0,0,0, 0,0, 0,4,0));
        tbl.push_back(mk(0,0,1,0,0, 1,0,0,0, 0,0, 0,4,0));
        tbl.push_back(mk(0,0,1,1,0, 1,0,0,0, 0,0, 1,4,0));
        tbl.push_back(mk(0,0,1,1,0, 1,0,0,0, 0,0, 1,5,0));
        tbl.push_back(mk(0,0,1,0,0, 0,1,0,0, 0,0, 0,6,0));
        tbl.push_back(mk(0,0,1,0,1, 0,0,0,0, 0,0, 0,6,0));
        tbl.push_back(mk(0,0,1,0,1, 0,0,0,0, 0,0, 0,6,0));
        runTable("frameA");

        // Async reset in the middle of a frame, then restart and abort.
        @(negedge clk);
        idleInputs(); start = 1; win_vld = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        #1;
        chk("rstmid.pre_x", 0, 32'(win_x), 1);
        chk("rstmid.pre_y", 0, 32'(win_y), 1);
        chk("rstmid.pre_busy", 0, 32'(busy), 1);
        rst = 1'b1;
        #1;
        checkResetValues("rstmid.async");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("rstmid.done_held", i, 32'(done), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkResetValues("rstmid.released");
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        #1;
        chk("restart.busy", 0, 32'(busy), 1);
        chk("restart.pop", 0, 32'(win_pop), 1);
        chk("restart.x", 0, 32'(win_x), 0);
        chk("restart.y", 0, 32'(win_y), 0);
        @(negedge clk);
        win_vld = 0; abort = 1;
        #1;
        chk("abort.x", 0, 32'(win_x), 1);
        chk("abort.pop", 0, 32'(win_pop), 0);
        @(negedge clk);
        abort = 0;
        #1;
        chk("abort.busy", 0, 32'(busy), 0);
        chk("abort.done", 0, 32'(done), 0);
        chk("abort.x", 1, 32'(win_x), 0);

        // Frame B: stray CE result in IDLE, then a frame with start pulsed in DRAIN.
        //                s a v c r  b d p xy x y  w a e
        tbl.push_back(mk(0,0,0,1,0, 0,0,0,1, 0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,1, 0,0, 0,0,1));
        tbl.push_back(mk(1,0,1,0,0, 0,0,0,1, 0,0, 0,0,1));
        tbl.push_back(mk(0,0,1,0,0, 1,0,1,1, 0,0, 0,0,1));
        tbl.push_back(mk(0,0,1,1,1, 1,0,1,1, 1,0, 1,0,1));
        tbl.push_back(mk(0,0,1,1,1, 1,0,1,1, 2,0, 1,1,1));
        tbl.push_back(mk(0,0,1,1,1, 1,0,1,1, 0,1, 1,2,1));
        tbl.push_back(mk(0,0,1,1,1, 1,0,1,1, 1,1, 1,3,1));
        tbl.push_back(mk(0,0,1,1,1, 1,0,1,1, 2,1, 1,4,1));
        tbl.push_back(mk(1,0,1,0,0, 1,0,0,0, 0,0, 0,5,1));
        tbl.push_back(mk(0,0,1,1,1, 1,0,0,0, 0,0, 1,5,1));
        tbl.push_back(mk(0,0,1,0,0, 0,1,0,0, 0,0, 0,6,1));
        tbl.push_back(mk(0,0,1,0,0, 0,0,0,0, 0,0, 0,6,1));
        runTable("frameB");

        // CRED=2 instance: credit exhaustion, single refill, same-cycle issue+return.
        @(negedge clk);
        idleInputs(); start2 = 1; win_vld2 = 1;
        #1;
        chk("cred2.idle_pop", 0, 32'(win_pop2), 0);
        @(negedge clk);
        start2 = 0;
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            pops += int'(win_pop2);
        end
        chk("cred2.starved_issues", 0, 32'(pops), 2);
        chk("cred2.starved_pop", 0, 32'(win_pop2), 0);
        @(negedge clk);
        cred_ret2 = 1;
        #1;
        chk("cred2.ret_cycle_pop", 0, 32'(win_pop2), 0);
        @(negedge clk);
        cred_ret2 = 0;
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            pops += int'(win_pop2);
        end
        chk("cred2.one_more_issue", 0, 32'(pops), 1);
        @(negedge clk);
        cred_ret2 = 1;
        #1;
        chk("cred2.refill_pop", 0, 32'(win_pop2), 0);
        @(negedge clk);
        #1;
        chk("cred2.same_cycle_pop", 0, 32'(win_pop2), 1);
        chk("cred2.same_cycle_x", 0, 32'(win_x2), 0);
        chk("cred2.same_cycle_y", 0, 32'(win_y2), 1);
        @(negedge clk);
        cred_ret2 = 0;
        #1;
        chk("cred2.next_pop", 0, 32'(win_pop2), 1);
        chk("cred2.next_x", 0, 32'(win_x2), 1);
        chk("cred2.next_y", 0, 32'(win_y2), 1);
        @(negedge clk);
        #1;
        chk("cred2.empty_pop", 0, 32'(win_pop2), 0);
        abort2 = 1;
        @(negedge clk);
        abort2 = 0; win_vld2 = 0;
        #1;
        chk("cred2.abort_busy", 0, 32'(busy2), 0);
        chk("cred2.err", 0, 32'(err2), 0);

        @(negedge clk);
        idleInputs();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
